// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - frame-synchronous game display state, lives and score sequencer
module game_state_ctrl #(
    parameter int HIT_FRAMES  = 30,
    parameter int FAIL_FRAMES = 60,
    parameter int LIVES       = 3,
    parameter int WIN_SCORE   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       vs,
    input  logic       hit_evt,
    input  logic       miss_evt,
    input  logic       start,
    output logic [1:0] state,
    output logic [2:0] lives,
    output logic [7:0] score,
    output logic       win,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HIT  = 2'd1,
        S_FAIL = 2'd2,
        S_END  = 2'd3
    } state_t;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] HIT_LOAD   = 8'(HIT_FRAMES - 1);
    localparam logic [7:0] FAIL_LOAD  = 8'(FAIL_FRAMES - 1);
    localparam logic [7:0] WIN_SC     = 8'(WIN_SCORE);

    state_t     cur_q, nxt;
    logic [2:0] lives_q, lives_d;
    logic [7:0] score_q, score_d, score_inc;
    logic       win_q, win_d;
    logic [7:0] cnt_q, cnt_d;

    logic vs_s1, vs_s2, vs_d;
    logic pend_hit, pend_miss, pend_start;
    logic eff_hit, eff_miss, eff_start;
    logic in_run;

    assign in_run = (cur_q == S_RUN);

    // Synchronisers reset high so releasing reset never looks like a vs fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vs_s1      <= 1'b1;
            vs_s2      <= 1'b1;
            vs_d       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_s1      <= vs;
            vs_s2      <= vs_s1;
            vs_d       <= vs_s2;
            frame_tick <= vs_d & ~vs_s2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_hit   <= 1'b0;
            pend_miss  <= 1'b0;
            pend_start <= 1'b0;
        end else if (frame_tick) begin
            pend_hit   <= 1'b0;
            pend_miss  <= 1'b0;
            pend_start <= 1'b0;
        end else begin
            pend_hit   <= pend_hit | (hit_evt & in_run);
            pend_miss  <= pend_miss | (miss_evt & in_run);
            pend_start <= pend_start | start;
        end
    end

    // A pulse landing on the tick cycle itself still counts for that tick.
    assign eff_hit   = pend_hit | (hit_evt & in_run);
    assign eff_miss  = pend_miss | (miss_evt & in_run);
    assign eff_start = pend_start | start;

    assign score_inc = (score_q == 8'hff) ? 8'hff : score_q + 8'd1;

    always_comb begin
        nxt     = cur_q;
        lives_d = lives_q;
        score_d = score_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            if (eff_start) begin
                nxt     = S_RUN;
                lives_d = LIVES_INIT;
                score_d = 8'd0;
                win_d   = 1'b0;
                cnt_d   = 8'd0;
            end else begin
                case (cur_q)
                    S_RUN: begin
                        if (eff_miss) begin
                            if (lives_q <= 3'd1) begin
                                lives_d = 3'd0;
                                win_d   = 1'b0;
                                nxt     = S_END;
                            end else begin
                                lives_d = lives_q - 3'd1;
                                cnt_d   = FAIL_LOAD;
                                nxt     = S_FAIL;
                            end
                        end else if (eff_hit) begin
                            score_d = score_inc;
                            if (score_inc == WIN_SC) begin
                                win_d = 1'b1;
                                nxt   = S_END;
                            end else begin
                                cnt_d = HIT_LOAD;
                                nxt   = S_HIT;
                            end
                        end
                    end
                    S_HIT, S_FAIL: begin
                        if (cnt_q == 8'd0) nxt = S_RUN;
                        else cnt_d = cnt_q - 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_q   <= S_RUN;
            lives_q <= LIVES_INIT;
            score_q <= 8'd0;
            win_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            cur_q   <= nxt;
            lives_q <= lives_d;
            score_q <= score_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = cur_q;
    assign lives = lives_q;
    assign score = score_q;
    assign win   = win_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed self-checking bench for game_state_ctrl
module tb_game_state_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       vs;
    logic       hit_evt, miss_evt, start;
    logic [1:0] state;
    logic [2:0] lives;
    logic [7:0] score;
    logic       win;
    logic       frame_tick;

    logic vs_run = 1'b0;
    logic vs_gen = 1'b1;
    logic vs_man = 1'b1;
    int   fcnt   = 10;
    int   n_checks = 0;
    int   n_pass   = 0;

    assign vs = vs_run ? vs_gen : vs_man;

    always #5 clock = ~clock;

    game_state_ctrl dut (
        .clock(clock), .reset(reset), .vs(vs),
        .hit_evt(hit_evt), .miss_evt(miss_evt), .start(start),
        .state(state), .lives(lives), .score(score), .win(win),
        .frame_tick(frame_tick)
    );

    // 40-clock frame with vs low for the first 4 clocks
    initial begin
        forever begin
            @(negedge clock);
            if (vs_run) begin
                fcnt   = (fcnt + 1) % 40;
                vs_gen = (fcnt < 4) ? 1'b0 : 1'b1;
            end
        end
    end

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            while (frame_tick !== 1'b1 && t < 200) begin
                @(negedge clock);
                t++;
            end
            n_checks++;
            if (t >= 200) $display("FAIL tick_timeout got no frame_tick exp frame_tick within 200 cycles");
            else n_pass++;
            @(negedge clock);
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clock);
        if (which == 0) hit_evt = 1'b1;
        else if (which == 1) miss_evt = 1'b1;
        else start = 1'b1;
        @(negedge clock);
        hit_evt = 1'b0; miss_evt = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick_n(1);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got %0d exp %0d", name, got, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        int seen [1:4];
        int ticks;
        vs_run = 1'b0; vs_man = 1'b1;
        hit_evt = 1'b0; miss_evt = 1'b0; start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (state !== 2'd0) $display("FAIL reset_state got %0d exp 0", state); else n_pass++;
        n_checks++; if (lives !== 3'd3) $display("FAIL reset_lives got %0d exp 3", lives); else n_pass++;
        n_checks++; if (score !== 8'd0) $display("FAIL reset_score got %0d exp 0", score); else n_pass++;
        n_checks++; if (win !== 1'b0 || frame_tick !== 1'b0) $display("FAIL reset_win_tick got %0d%0d exp 00", win, frame_tick); else n_pass++;
        reset = 1'b1;
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (frame_tick === 1'b1) ticks++;
        end
        n_checks++; if (ticks !== 0) $display("FAIL no_tick_after_release got %0d exp 0", ticks); else n_pass++;
        vs_man = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            seen[i] = int'(frame_tick);
        end
        n_checks++;
        if (seen[1] !== 0 || seen[2] !== 0 || seen[3] !== 1 || seen[4] !== 0)
            $display("FAIL tick_latency got %0d%0d%0d%0d exp 0010", seen[1], seen[2], seen[3], seen[4]);
        else n_pass++;
        vs_man = 1'b1;
        repeat (4) @(negedge clock);
        fcnt = 10; vs_gen = 1'b1; vs_run = 1'b1;
        ticks = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (frame_tick === 1'b1) ticks++;
        end
        n_checks++; if (ticks !== 3) $display("FAIL ticks_per_3_frames got %0d exp 3", ticks); else n_pass++;
    endtask

    task automatic test_hit();
        do_reset();
        pulse(0);
        pulse(0);
        n_checks++; if (state !== 2'd0) $display("FAIL hit_before_tick got %0d exp 0", state); else n_pass++;
        tick_n(1);
        n_checks++; if (state !== 2'd1) $display("FAIL hit_state got %0d exp 1", state); else n_pass++;
        n_checks++; if (score !== 8'd1) $display("FAIL hit_score_once got %0d exp 1", score); else n_pass++;
        pulse(0);
        tick_n(29);
        n_checks++; if (state !== 2'd1) $display("FAIL hit_hold_29 got %0d exp 1", state); else n_pass++;
        n_checks++; if (score !== 8'd1) $display("FAIL hit_ignored_in_hit got %0d exp 1", score); else n_pass++;
        tick_n(1);
        n_checks++; if (state !== 2'd0) $display("FAIL hit_return_run got %0d exp 0", state); else n_pass++;
    endtask

    task automatic test_hit_and_miss();
        do_reset();
        @(negedge clock);
        hit_evt = 1'b1; miss_evt = 1'b1;
        @(negedge clock);
        hit_evt = 1'b0; miss_evt = 1'b0;
        tick_n(1);
        n_checks++; if (state !== 2'd2) $display("FAIL hm_state got %0d exp 2", state); else n_pass++;
        n_checks++; if (lives !== 3'd2) $display("FAIL hm_lives got %0d exp 2", lives); else n_pass++;
        n_checks++; if (score !== 8'd0) $display("FAIL hm_score got %0d exp 0", score); else n_pass++;
        tick_n(59);
        n_checks++; if (state !== 2'd2) $display("FAIL fail_hold_59 got %0d exp 2", state); else n_pass++;
        tick_n(1);
        n_checks++; if (state !== 2'd0) $display("FAIL fail_return_run got %0d exp 0", state); else n_pass++;
    endtask

    task automatic test_three_misses();
        do_reset();
        for (int m = 1; m <= 3; m++) begin
            pulse(1);
            tick_n(1);
            chk("miss_lives", int'(lives), 3 - m);
            if (m < 3) begin
                chk("miss_state_fail", int'(state), 2);
                tick_n(60);
                chk("miss_back_run", int'(state), 0);
            end
        end
        chk("lose_state", int'(state), 3);
        chk("lose_win", int'(win), 0);
        pulse(0);
        tick_n(1);
        chk("end_hit_ignored", int'(score), 0);
        chk("end_holds", int'(state), 3);
    endtask

    task automatic test_win_and_restart();
        do_reset();
        for (int h = 1; h <= 10; h++) begin
            pulse(0);
            tick_n(1);
            if (h < 10) tick_n(30);
        end
        chk("win_score", int'(score), 10);
        chk("win_state", int'(state), 3);
        chk("win_flag", int'(win), 1);
        pulse(2);
        n_checks++; if (state !== 2'd3) $display("FAIL start_waits_tick got %0d exp 3", state); else n_pass++;
        tick_n(1);
        chk("restart_state", int'(state), 0);
        chk("restart_lives", int'(lives), 3);
        chk("restart_score", int'(score), 0);
        chk("restart_win", int'(win), 0);
    endtask

    task automatic test_priority();
        do_reset();
        pulse(1);
        pulse(2);
        tick_n(1);
        chk("prio_start_state", int'(state), 0);
        chk("prio_start_lives", int'(lives), 3);
    endtask

    task automatic test_reset_mid_fail();
        do_reset();
        pulse(1);
        tick_n(20);
        chk("pre_reset_fail", int'(state), 2);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0) $display("FAIL async_reset_state got %0d exp 0", state); else n_pass++;
        n_checks++; if (lives !== 3'd3) $display("FAIL async_reset_lives got %0d exp 3", lives); else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        tick_n(1);
        chk("post_reset_idle", int'(state), 0);
    endtask

    initial begin
        reset = 1'b0;
        hit_evt = 1'b0; miss_evt = 1'b0; start = 1'b0;
        test_reset();
        test_hit();
        test_hit_and_miss();
        test_three_misses();
        test_win_and_restart();
        test_priority();
        test_reset_mid_fail();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Sequences the 2-bit display state consumed by the VGA colour generator: running, hit, fail, ending.
- Takes game events from the game logic: hit, miss and start pulses.
- Tracks lives and score.
- Applies every state change only at a frame boundary, derived from the VGA vs output, so a frame never shows two states.

Parameters:
- HIT_FRAMES, 30, frames the hit state is held before returning to running (1..255).
- FAIL_FRAMES, 60, frames the fail state is held before returning to running (1..255).
- LIVES, 3, lives loaded at reset and at restart (1..7).
- WIN_SCORE, 10, score at which the game ends with a win (1..255).

Ports:
- clock  input  1  system clock, same clock that drives the VGA block
- reset  input  1  asynchronous, active-low reset
- vs  input  1  vertical sync from VGA block, active low, asynchronous to clock domain logic
- hit_evt  input  1  one-clock pulse: zombie hit
- miss_evt  input  1  one-clock pulse: zombie reached player
- start  input  1  one-clock pulse: restart request
- state  output  2  display state: 0 running, 1 hit, 2 fail, 3 ending
- lives  output  3  remaining lives
- score  output  8  current score
- win  output  1  1 when ending was reached by score, 0 when reached by lives
- frame_tick  output  1  one-clock pulse at each frame start

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=0 (running), lives=LIVES, score=0, win=0, frame_tick=0
  - hold counter=0, all pending flags cleared
  - both vs synchroniser flops=1, so there is no spurious tick on reset release
- Reset mid-operation aborts any hold and returns to these values immediately.
- Frame tick:
  - vs passes through a 2-flop synchroniser plus an edge register.
  - frame_tick=1 for exactly one clock on the synchronised 1->0 transition of vs.
  - Latency from the vs edge to frame_tick is 3 clocks.
- Pending flags pend_hit, pend_miss, pend_start:
  - Set by the input pulse.
  - pend_hit and pend_miss are captured only while state=running; in other states they are discarded.
  - pend_start is captured in any state.
  - A pulse arriving in the same cycle as frame_tick counts as pending for that tick (effective flag = pend OR pulse).
  - All flags are cleared on every frame_tick.
- FSM: states RUN=0, HIT=1, FAIL=2, END=3, mapped directly onto the state output. Transitions happen only on frame_tick. Priority is start > miss > hit.
- Any state, start pending:
  - lives=LIVES, score=0, win=0, counter=0 -> RUN.
- RUN, miss pending:
  - If lives=1: lives=0 -> END, win=0.
  - Otherwise: lives-1, counter=FAIL_FRAMES-1 -> FAIL.
  - A coincident hit is discarded.
- RUN, hit pending only:
  - score+1.
  - If the new score = WIN_SCORE -> END, win=1.
  - Otherwise counter=HIT_FRAMES-1 -> HIT.
- HIT / FAIL:
  - counter=0 -> RUN; otherwise counter-1.
  - Net result: the state is displayed for exactly HIT_FRAMES or FAIL_FRAMES full frames.
- END: holds; only start leaves it.
- Width and arithmetic rules:
  - score saturates at 255; it is unreachable beyond WIN_SCORE.
  - lives never decrements below 0.
  - counter is 8 bits.
- All outputs are registered. state, lives, score and win change in the cycle after frame_tick=1 and are stable for the whole frame.
- Multiple pulses of the same event within one frame count once.

Test Plan:
- Reset release with vs toggling at 525-line frame period -> state=0, lives=3, score=0; one frame_tick per vs falling edge, 3 clocks after it; no tick in the first 3 clocks after reset release.
- hit_evt pulse mid-frame in RUN -> state stays 0 until the next frame_tick, then state=1 and score=1; exactly 30 frames later state=0; hit_evt during HIT ignored, score stays 1.
- hit_evt and miss_evt in the same frame -> at tick state=2, lives=2, score=0; after 60 frames state=0.
- Three misses, each in RUN -> lives 3,2,1,0; after the third, state=3 and win=0; a later hit_evt leaves score unchanged.
- Ten hits with each HIT hold completed -> the tenth sets score=10, state=3, win=1; start pulse -> at the next tick state=0, lives=3, score=0, win=0.
- Assert reset for 1 cycle during FAIL hold with counter=40 -> state=0 and lives=3 immediately; the next frame_tick with no events keeps state=0.
